// File: rtl/spi_s_p_pkg.sv
// spi_s_p_pkg: shared types and constants for the SPI-style serial receiver.
package spi_s_p_pkg;

    typedef enum logic [1:0] {WAIT_HI, IDLE, ACTIVE} state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Bit counter must hold 0..DATA_W+1 so over-length frames stay distinguishable.
    function automatic int cnt_w(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with a history flop for edge detection.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic MCLK,
    input  logic RST_N,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              hist;

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            sr   <= {STAGES{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            hist <= sr[STAGES-1];
        end
    end

    assign sync = sr[STAGES-1];
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/spi_s_p_rx.sv
// spi_s_p_rx: oversampling 3-wire SPI responder; deserializes MSB-first frames
// into parallel words with one-cycle valid / frame-error strobes.
module spi_s_p_rx
    import spi_s_p_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              MCLK,
    input  logic              RST_N,
    input  logic              CS_N,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              FRAME_ERR,
    output logic              BUSY
);

    localparam int CW = cnt_w(DATA_W);
    localparam int HW = $clog2(SYNC_STAGES + 2);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_rise, mosi_s;
    logic unused_sclk_s, unused_sclk_fall, unused_mosi_rise, unused_mosi_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .MCLK(MCLK), .RST_N(RST_N), .din(CS_N),
        .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .MCLK(MCLK), .RST_N(RST_N), .din(SCLK),
        .sync(unused_sclk_s), .rise(sclk_rise), .fall(unused_sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .MCLK(MCLK), .RST_N(RST_N), .din(MOSI),
        .sync(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift;
    logic [CW-1:0]     count;
    logic [HW-1:0]     hi_cnt;
    logic              clr, shift_en, done_ok, done_err;

    always_ff @(posedge MCLK) begin
        if (!RST_N)
            state <= WAIT_HI;
        else
            state <= state_nx;
    end

    // The synchronizer flops preset high, so leaving WAIT_HI needs CS_N seen
    // high for longer than the reset-value prefill could fake it.
    always_comb begin
        state_nx = (state == WAIT_HI) ? ((cs_s && hi_cnt == HW'(SYNC_STAGES)) ? IDLE : WAIT_HI)
                 : (state == IDLE)    ? (cs_fall ? ACTIVE : IDLE)
                 :                      (cs_rise ? IDLE : ACTIVE);
    end

    always_comb begin
        clr      = (state == IDLE) && cs_fall;
        shift_en = (state == ACTIVE) && sclk_rise && !cs_s;
        done_ok  = (state == ACTIVE) && cs_rise && (count == CW'(DATA_W));
        done_err = (state == ACTIVE) && cs_rise && (count != CW'(DATA_W));
    end

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            shift     <= '0;
            count     <= '0;
            hi_cnt    <= '0;
            RDATA     <= '0;
            RVALID    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            RVALID    <= done_ok;
            FRAME_ERR <= done_err;
            hi_cnt    <= (state == WAIT_HI && cs_s) ? hi_cnt + HW'(hi_cnt != HW'(SYNC_STAGES)) : '0;
            if (clr) begin
                shift <= '0;
                count <= '0;
            end else if (shift_en) begin
                shift <= {shift[DATA_W-2:0], mosi_s};
                count <= (count == CW'(DATA_W + 1)) ? count : count + 1'b1;
            end
            if (done_ok)
                RDATA <= shift;
        end
    end

    assign BUSY = (state == ACTIVE);

endmodule

// File: tb/tb_spi_s_p_rx.sv
// tb_spi_s_p_rx: randomized scoreboard bench; frames are modelled by bit length
// alone (exactly 16 bits -> new word, anything else -> error, word held).
module tb_spi_s_p_rx;

    logic        MCLK = 1'b0;
    logic        RST_N, CS_N, SCLK, MOSI;
    logic [15:0] RDATA;
    logic        RVALID, FRAME_ERR, BUSY;

    spi_s_p_rx dut (
        .MCLK(MCLK), .RST_N(RST_N), .CS_N(CS_N), .SCLK(SCLK), .MOSI(MOSI),
        .RDATA(RDATA), .RVALID(RVALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        bit          ok;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] last_good;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge MCLK);
        #2;
    endtask

    task automatic send_bit(input logic b, input int h, input bit junk);
        MOSI = b;
        SCLK = 1'b0;
        cyc(h);
        SCLK = 1'b1;
        cyc(1);
        if (junk) MOSI = 1'($urandom);
        cyc(h - 1);
    endtask

    task automatic frame(input int n, input logic [31:0] v, input int h, input int g, input bit junk);
        if (n == 16) begin
            exp_q.push_back('{1'b1, v[15:0]});
            last_good = v[15:0];
        end else begin
            exp_q.push_back('{1'b0, last_good});
        end
        CS_N = 1'b0;
        cyc(h);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], h, junk);
        chk("busy_in_frame", BUSY, 1);
        CS_N = 1'b1;
        cyc(g);
    endtask

    always @(negedge MCLK) begin
        if (RST_N && (RVALID || FRAME_ERR)) begin
            exp_t e;
            chk("strobe_exclusive", RVALID & FRAME_ERR, 0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: got RVALID=%0b FRAME_ERR=%0b expected none at %0t",
                         RVALID, FRAME_ERR, $time);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", RVALID, e.ok);
                chk("rdata", RDATA, e.data);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; CS_N = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        last_good = 16'h0;
        cyc(4);
        chk("reset_rdata", RDATA, 0);
        chk("reset_rvalid", RVALID, 0);
        chk("reset_frame_err", FRAME_ERR, 0);
        chk("reset_busy", BUSY, 0);
        RST_N = 1'b1;
        cyc(8);
        chk("idle_busy", BUSY, 0);

        frame(16, 32'hA5C3, 4, 4, 1'b0);
        frame(15, 32'h1234, 4, 4, 1'b0);
        frame(16, 32'h1234, 4, 4, 1'b0);
        frame(17, 32'h1FFFF, 4, 4, 1'b0);

        // reset in the middle of a frame with CS_N held low
        CS_N = 1'b0;
        cyc(4);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 4, 1'b0);
        RST_N = 1'b0;
        cyc(3);
        RST_N = 1'b1;
        last_good = 16'h0;
        for (int i = 0; i < 8; i++) begin
            send_bit(i[0], 4, 1'b0);
            chk("wait_hi_busy", BUSY, 0);
        end
        chk("rdata_after_reset", RDATA, 0);
        CS_N = 1'b1;
        cyc(10);
        chk("wait_hi_exit_busy", BUSY, 0);
        frame(16, 32'hBEEF, 4, 4, 1'b0);

        frame(16, 32'h0001, 3, 3, 1'b0);
        frame(16, 32'h8000, 3, 3, 1'b0);
        frame(16, 32'hFFFF, 3, 3, 1'b0);

        frame(0, 32'h0, 4, 4, 1'b1);
        frame(16, 32'h5A5A, 4, 4, 1'b1);
        frame(0, 32'h0, 3, 3, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int n;
            case ($urandom_range(0, 5))
                0:       n = 15;
                1:       n = 17;
                2:       n = $urandom_range(0, 20);
                default: n = 16;
            endcase
            frame(n, $urandom, $urandom_range(3, 6), $urandom_range(3, 6), 1'($urandom));
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_rdata", RDATA, last_good);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
